// File: rtl/pdh_dac_sweep_ctrl_if.sv
// Command, sweep-config and DAC-stream bundle between the PS command decoder,
// the sweep controller and the DAC AXI-Stream output.
interface pdh_dac_sweep_ctrl_if #(
  parameter int CODE_W  = 14,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 16
);
  logic               start_i;
  logic               stop_i;
  logic               cfg_chan_i;
  logic [CODE_W-1:0]  cfg_min_i;
  logic [CODE_W-1:0]  cfg_max_i;
  logic [CODE_W-1:0]  cfg_step_i;
  logic [DWELL_W-1:0] cfg_dwell_i;
  logic               host_wr_i;
  logic               host_sel_i;
  logic [CODE_W-1:0]  host_code_i;
  logic [31:0]        dac_tdata_o;
  logic               dac_tvalid_o;
  logic               busy_o;
  logic [1:0]         state_o;
  logic [CNT_W-1:0]   period_cnt_o;
  logic               err_o;

  modport master (
    output start_i, stop_i, cfg_chan_i, cfg_min_i, cfg_max_i, cfg_step_i, cfg_dwell_i,
           host_wr_i, host_sel_i, host_code_i,
    input  dac_tdata_o, dac_tvalid_o, busy_o, state_o, period_cnt_o, err_o
  );

  modport slave (
    input  start_i, stop_i, cfg_chan_i, cfg_min_i, cfg_max_i, cfg_step_i, cfg_dwell_i,
           host_wr_i, host_sel_i, host_code_i,
    output dac_tdata_o, dac_tvalid_o, busy_o, state_o, period_cnt_o, err_o
  );
endinterface

// File: rtl/pdh_dac_sweep_ctrl.sv
// Owner of the two-channel DAC word: arbitrates host code writes against a
// triangle sweep engine that scans one channel between latched limits.
module pdh_dac_sweep_ctrl #(
  parameter int CODE_W  = 14,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  pdh_dac_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;

  state_t             state_r;
  logic               busy_r;
  logic               chan_r;
  logic               tvalid_r;
  logic               err_r;
  logic [CODE_W-1:0]  min_r;
  logic [CODE_W-1:0]  max_r;
  logic [CODE_W-1:0]  step_r;
  logic [CODE_W-1:0]  ch0_r;
  logic [CODE_W-1:0]  ch1_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic [CNT_W-1:0]   period_r;

  logic                start_ok_s;
  logic                start_acc_s;
  logic                host_ok_s;
  logic                step_due_s;
  logic                turn_s;
  logic [CODE_W-1:0]   swept_s;
  logic [CODE_W-1:0]   step_code_s;
  logic [CODE_W:0]     up_next_s;
  logic signed [CODE_W:0] dn_next_s;

  function automatic logic [31:0] pack_word(input logic [CODE_W-1:0] c1,
                                            input logic [CODE_W-1:0] c0);
    return {{(16-CODE_W){1'b0}}, c1, {(16-CODE_W){1'b0}}, c0};
  endfunction

  // Request qualification and the code a due sweep step would produce
  always_comb begin
    swept_s     = chan_r ? ch1_r : ch0_r;
    start_ok_s  = (bus.cfg_min_i < bus.cfg_max_i) && (bus.cfg_step_i != {CODE_W{1'b0}});
    start_acc_s = bus.start_i && !bus.stop_i && start_ok_s;
    host_ok_s   = bus.host_wr_i && (!busy_r || (bus.host_sel_i != chan_r));
    step_due_s  = busy_r && (dwell_cnt_r == dwell_r);
    up_next_s   = {1'b0, swept_s} + {1'b0, step_r};
    dn_next_s   = $signed({1'b0, swept_s}) - $signed({1'b0, step_r});
    turn_s      = 1'b0;
    step_code_s = swept_s;
    // One extra bit keeps overshoot past max and undershoot below zero visible
    case (state_r)
      UP: begin
        if (up_next_s >= {1'b0, max_r}) begin
          turn_s      = 1'b1;
          step_code_s = max_r;
        end else begin
          step_code_s = up_next_s[CODE_W-1:0];
        end
      end
      DOWN: begin
        if (dn_next_s <= $signed({1'b0, min_r})) begin
          turn_s      = 1'b1;
          step_code_s = min_r;
        end else begin
          step_code_s = dn_next_s[CODE_W-1:0];
        end
      end
      default: begin
        turn_s      = 1'b0;
        step_code_s = swept_s;
      end
    endcase
  end

  // Sweep FSM, channel registers and registered stream/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      chan_r      <= 1'b0;
      min_r       <= {CODE_W{1'b0}};
      max_r       <= {CODE_W{1'b0}};
      step_r      <= {CODE_W{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      ch0_r       <= {CODE_W{1'b0}};
      ch1_r       <= {CODE_W{1'b0}};
      period_r    <= {CNT_W{1'b0}};
      tvalid_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      tvalid_r <= 1'b0;
      err_r    <= (bus.host_wr_i && !host_ok_s) || (bus.start_i && !bus.stop_i && !start_ok_s);
      if (host_ok_s) begin
        tvalid_r <= 1'b1;
        if (bus.host_sel_i) ch1_r <= bus.host_code_i;
        else                ch0_r <= bus.host_code_i;
      end
      // Sweep writes come after the host write so a start overrides it on the swept channel
      if (bus.stop_i) begin
        state_r     <= IDLE;
        busy_r      <= 1'b0;
        dwell_cnt_r <= {DWELL_W{1'b0}};
      end else if (start_acc_s) begin
        chan_r      <= bus.cfg_chan_i;
        min_r       <= bus.cfg_min_i;
        max_r       <= bus.cfg_max_i;
        step_r      <= bus.cfg_step_i;
        dwell_r     <= bus.cfg_dwell_i;
        dwell_cnt_r <= {DWELL_W{1'b0}};
        period_r    <= {CNT_W{1'b0}};
        state_r     <= UP;
        busy_r      <= 1'b1;
        tvalid_r    <= 1'b1;
        if (bus.cfg_chan_i) ch1_r <= bus.cfg_min_i;
        else                ch0_r <= bus.cfg_min_i;
      end else if (step_due_s) begin
        dwell_cnt_r <= {DWELL_W{1'b0}};
        tvalid_r    <= 1'b1;
        if (chan_r) ch1_r <= step_code_s;
        else        ch0_r <= step_code_s;
        if (turn_s) begin
          if (state_r == UP) begin
            state_r <= DOWN;
          end else begin
            state_r  <= UP;
            period_r <= period_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end else if (busy_r) begin
        dwell_cnt_r <= dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.dac_tdata_o  = pack_word(ch1_r, ch0_r);
  assign bus.dac_tvalid_o = tvalid_r;
  assign bus.busy_o       = busy_r;
  assign bus.state_o      = state_r;
  assign bus.period_cnt_o = period_r;
  assign bus.err_o        = err_r;
endmodule

// File: tb/tb_pdh_dac_sweep_ctrl.sv
// Scoreboard bench for pdh_dac_sweep_ctrl: expected DAC beats are queued with
// the cycle they must appear in and matched by a negedge monitor.
module tb_pdh_dac_sweep_ctrl;
  localparam int CODE_W = 14, DWELL_W = 16, CNT_W = 16;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   idx;
  exp_t sb[$];

  pdh_dac_sweep_ctrl_if #(.CODE_W(CODE_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) bus ();
  pdh_dac_sweep_ctrl #(.CODE_W(CODE_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every tvalid beat must match a queued word for this exact cycle
  initial forever begin
    @(negedge clk);
    idx = -1;
    foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
    if (bus.dac_tvalid_o === 1'b1) begin
      total++;
      if (idx < 0) begin
        bad++;
        $display("FAIL beat_unexpected cyc=%0d got=%h", cyc, bus.dac_tdata_o);
      end else begin
        if (bus.dac_tdata_o !== sb[idx].data) begin
          bad++;
          $display("FAIL beat_data cyc=%0d got=%h exp=%h", cyc, bus.dac_tdata_o, sb[idx].data);
        end
        sb.delete(idx);
      end
    end else if (idx >= 0) begin
      total++;
      bad++;
      $display("FAIL beat_missing cyc=%0d exp=%h", cyc, sb[idx].data);
      sb.delete(idx);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_word(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input logic ch, input logic [13:0] mn, input logic [13:0] mx,
                         input logic [13:0] st, input logic [15:0] dw);
    bus.cfg_chan_i  = ch;
    bus.cfg_min_i   = mn;
    bus.cfg_max_i   = mx;
    bus.cfg_step_i  = st;
    bus.cfg_dwell_i = dw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.dac_tdata_o !== 32'h0 || bus.dac_tvalid_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%h/%b/%b exp=0/0/0", bus.dac_tdata_o, bus.dac_tvalid_o, bus.err_o);
    end
    total++;
    if (bus.state_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.period_cnt_o !== 16'h0) begin
      bad++;
      $display("FAIL reset_state got=%b/%b/%0d exp=00/0/0", bus.state_o, bus.busy_o, bus.period_cnt_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_host_write();
    int c = cyc;
    expect_word(c + 1, 32'h0000_0123);
    bus.host_sel_i = 1'b0; bus.host_code_i = 14'h0123; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    @(negedge clk);
    c = cyc;
    expect_word(c + 1, 32'h1ABC_0123);
    bus.host_sel_i = 1'b1; bus.host_code_i = 14'h1ABC; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    @(negedge clk);
    c = cyc;
    expect_word(c + 1, 32'h1ABC_3FFF);
    expect_word(c + 2, 32'h2000_3FFF);
    bus.host_sel_i = 1'b0; bus.host_code_i = 14'h3FFF; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_sel_i = 1'b1; bus.host_code_i = 14'h2000;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL host_pending got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_sweep_ch0();
    logic [13:0] seq [6] = '{14'h10, 14'h20, 14'h30, 14'h20, 14'h10, 14'h20};
    int c;
    set_cfg(1'b0, 14'h10, 14'h30, 14'h10, 16'd2);
    c = cyc;
    for (int k = 0; k < 6; k++) expect_word(c + 1 + 3 * k, {2'b00, 14'h2000, 2'b00, seq[k]});
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    set_cfg(1'b1, 14'h0, 14'h3FFF, 14'h1, 16'd0);
    total++;
    if (bus.state_o !== 2'b01 || bus.busy_o !== 1'b1) begin
      bad++; $display("FAIL sweep0_up got=%b/%b exp=01/1", bus.state_o, bus.busy_o);
    end
    go_to(c + 7);
    total++;
    if (bus.state_o !== 2'b10) begin bad++; $display("FAIL sweep0_down got=%b exp=10", bus.state_o); end
    go_to(c + 12);
    total++;
    if (bus.period_cnt_o !== 16'd0) begin bad++; $display("FAIL sweep0_period0 got=%0d exp=0", bus.period_cnt_o); end
    go_to(c + 13);
    total++;
    if (bus.period_cnt_o !== 16'd1 || bus.state_o !== 2'b01) begin
      bad++; $display("FAIL sweep0_period1 got=%0d/%b exp=1/01", bus.period_cnt_o, bus.state_o);
    end
    go_to(c + 16);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    total++;
    if (bus.state_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL stop_idle got=%b/%b exp=00/0", bus.state_o, bus.busy_o);
    end
    go_to(c + 25);
    total++;
    if (bus.dac_tdata_o !== 32'h2000_0020 || sb.size() != 0) begin
      bad++; $display("FAIL stop_frozen got=%h/%0d exp=20000020/0", bus.dac_tdata_o, sb.size());
    end
  endtask

  task automatic test_sweep_ch1_clamp();
    logic [13:0] seq [7] = '{14'h00, 14'h10, 14'h20, 14'h25, 14'h15, 14'h05, 14'h00};
    int c;
    set_cfg(1'b1, 14'h0, 14'h25, 14'h10, 16'd0);
    c = cyc;
    for (int k = 0; k < 7; k++) expect_word(c + 1 + k, {2'b00, seq[k], 2'b00, 14'h20});
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    go_to(c + 6);
    total++;
    if (bus.period_cnt_o !== 16'd0) begin bad++; $display("FAIL sweep1_period0 got=%0d exp=0", bus.period_cnt_o); end
    go_to(c + 7);
    total++;
    if (bus.period_cnt_o !== 16'd1) begin bad++; $display("FAIL sweep1_period1 got=%0d exp=1", bus.period_cnt_o); end
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    go_to(c + 12);
    total++;
    if (bus.dac_tdata_o !== 32'h0000_0020 || sb.size() != 0 || bus.state_o !== 2'b00) begin
      bad++; $display("FAIL sweep1_end got=%h/%0d/%b exp=00000020/0/00", bus.dac_tdata_o, sb.size(), bus.state_o);
    end
  endtask

  task automatic test_invalid_start();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_cfg(1'b0, 14'h40, 14'h40, 14'h1, 16'd0);
      else        set_cfg(1'b0, 14'h0, 14'h40, 14'h0, 16'd0);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      total++;
      if (bus.err_o !== 1'b1 || bus.state_o !== 2'b00 || bus.dac_tdata_o !== 32'h0000_0020) begin
        bad++; $display("FAIL bad_start%0d got=%b/%b/%h exp=1/00/00000020", k, bus.err_o, bus.state_o, bus.dac_tdata_o);
      end
      @(negedge clk);
      total++;
      if (bus.err_o !== 1'b0) begin bad++; $display("FAIL bad_start_pulse%0d got=%b exp=0", k, bus.err_o); end
    end
  endtask

  task automatic test_host_arbitration();
    int c;
    set_cfg(1'b0, 14'h10, 14'h30, 14'h10, 16'd2);
    c = cyc;
    expect_word(c + 1, 32'h0000_0010);
    expect_word(c + 2, 32'h0AAA_0010);
    expect_word(c + 4, 32'h0AAA_0020);
    expect_word(c + 7, 32'h0555_0030);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.host_sel_i = 1'b1; bus.host_code_i = 14'h0AAA; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    total++;
    if (bus.err_o !== 1'b0) begin bad++; $display("FAIL host_other_err got=%b exp=0", bus.err_o); end
    go_to(c + 4);
    bus.host_sel_i = 1'b0; bus.host_code_i = 14'h0155; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    total++;
    if (bus.err_o !== 1'b1) begin bad++; $display("FAIL host_swept_err got=%b exp=1", bus.err_o); end
    go_to(c + 6);
    bus.host_sel_i = 1'b1; bus.host_code_i = 14'h0555; bus.host_wr_i = 1'b1;
    @(negedge clk);
    bus.host_wr_i = 1'b0;
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    go_to(c + 14);
    total++;
    if (bus.dac_tdata_o !== 32'h0555_0030 || sb.size() != 0) begin
      bad++; $display("FAIL host_merge_end got=%h/%0d exp=05550030/0", bus.dac_tdata_o, sb.size());
    end
  endtask

  task automatic test_stop_start_same();
    int c = cyc;
    bus.start_i = 1'b1; bus.stop_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.stop_i = 1'b0;
    total++;
    if (bus.state_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++; $display("FAIL stop_wins got=%b/%b/%b exp=00/0/0", bus.state_o, bus.busy_o, bus.err_o);
    end
    go_to(c + 6);
    total++;
    if (bus.dac_tdata_o !== 32'h0555_0030) begin bad++; $display("FAIL stop_wins_data got=%h exp=05550030", bus.dac_tdata_o); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [13:0] seq [6] = '{14'h10, 14'h20, 14'h30, 14'h20, 14'h10, 14'h20};
    int c;
    set_cfg(1'b0, 14'h10, 14'h30, 14'h10, 16'd0);
    c = cyc;
    for (int k = 0; k < 6; k++) expect_word(c + 1 + k, {2'b00, 14'h0555, 2'b00, seq[k]});
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    go_to(c + 6);
    total++;
    if (bus.period_cnt_o !== 16'd1) begin bad++; $display("FAIL pre_rst_period got=%0d exp=1", bus.period_cnt_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.dac_tdata_o !== 32'h0 || bus.state_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.period_cnt_o !== 16'd0) begin
      bad++; $display("FAIL rst_mid got=%h/%b/%b/%0d exp=0/00/0/0", bus.dac_tdata_o, bus.state_o, bus.busy_o, bus.period_cnt_o);
    end
    go_to(c + 14);
    total++;
    if (bus.dac_tdata_o !== 32'h0 || sb.size() != 0) begin
      bad++; $display("FAIL rst_quiet got=%h/%0d exp=0/0", bus.dac_tdata_o, sb.size());
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.host_wr_i = 1'b0;
    bus.host_sel_i = 1'b0; bus.host_code_i = 14'h0;
    set_cfg(1'b0, 14'h0, 14'h0, 14'h0, 16'd0);
    test_reset();
    test_host_write();
    test_sweep_ch0();
    test_sweep_ch1_clamp();
    test_invalid_start();
    test_host_arbitration();
    test_stop_start_same();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
